// File: rtl/uart_rx_tampon_if.sv
// Byte stream bundle between a UART receiver, the receive FIFO
// and its consumer. Parameterised so the fill count width tracks depth.
interface uart_rx_tampon_if #(
    parameter int DERINLIK = 8
);
    localparam int CW = $clog2(DERINLIK) + 1;

    logic [7:0]    al_veri;
    logic          al_gecerli;
    logic          veri_hazir;
    logic          temizle;
    logic [31:0]   veri;
    logic          veri_gecerli;
    logic [CW-1:0] doluluk;
    logic          yari_dolu;
    logic          tasma;

    modport master (
        output al_veri, al_gecerli, veri_hazir, temizle,
        input  veri, veri_gecerli, doluluk, yari_dolu, tasma
    );

    modport slave (
        input  al_veri, al_gecerli, veri_hazir, temizle,
        output veri, veri_gecerli, doluluk, yari_dolu, tasma
    );
endinterface

// File: rtl/uart_rx_tampon.sv
// Fall-through receive FIFO for UART bytes with fill-level flag,
// sticky overflow flag and synchronous flush.
module uart_rx_tampon #(
    parameter int DERINLIK = 8,
    parameter int ESIK     = 6
) (
    input  logic             clk_g,
    input  logic             rst_g,
    uart_rx_tampon_if.slave  io_bus
);
    localparam int AW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
    localparam int CW = $clog2(DERINLIK) + 1;
    localparam logic [CW-1:0] LP_DERIN = CW'(DERINLIK);
    localparam logic [CW-1:0] LP_ESIK  = CW'(ESIK);
    localparam logic [CW-1:0] LP_ONE_C = CW'(1);
    localparam logic [AW-1:0] LP_ONE_A = AW'(1);

    logic [7:0]    r_mem [DERINLIK];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_tasma;

    logic w_bos;
    logic w_dolu;
    logic w_aktif;
    logic w_pop;
    logic w_push;
    logic w_ovf;

    assign w_bos   = (r_count == '0);
    assign w_dolu  = (r_count == LP_DERIN);
    assign w_aktif = ~io_bus.temizle & ~rst_g;
    assign w_pop   = ~w_bos & io_bus.veri_hazir & w_aktif;
    assign w_push  = io_bus.al_gecerli & w_aktif & (~w_dolu | w_pop);
    assign w_ovf   = io_bus.al_gecerli & w_aktif & w_dolu & ~w_pop;

    // Byte storage; contents are don't-care until written.
    always_ff @(posedge clk_g) begin
        if (w_push) begin
            r_mem[r_wptr] <= io_bus.al_veri;
        end
    end

    // Pointers and fill count; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk_g) begin
        if (rst_g || io_bus.temizle) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + LP_ONE_A;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + LP_ONE_A;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + LP_ONE_C;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - LP_ONE_C;
            end
        end
    end

    // Sticky overflow: set by a dropped byte, cleared only by flush or reset.
    always_ff @(posedge clk_g) begin
        if (rst_g || io_bus.temizle) begin
            r_tasma <= 1'b0;
        end else if (w_ovf) begin
            r_tasma <= 1'b1;
        end
    end

    assign io_bus.veri         = w_bos ? 32'h0 : {24'h0, r_mem[r_rptr]};
    assign io_bus.veri_gecerli = ~w_bos;
    assign io_bus.doluluk      = r_count;
    assign io_bus.yari_dolu    = (r_count >= LP_ESIK);
    assign io_bus.tasma        = r_tasma;
endmodule

// File: doc/uart_rx_tampon.md
UART_RX_TAMPON -- requirements
Module: uart_rx_tampon

Interface
REQ-001 The block SHALL have parameter DERINLIK, default 8, FIFO depth in bytes; legal values are powers of two, 2..256.
REQ-002 The block SHALL have parameter ESIK, default 6, fill level at which yari_dolu asserts; legal range is 1..DERINLIK.
REQ-003 The block SHALL have port clk_g, input, width 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_g, input, width 1, synchronous active-high reset.
REQ-005 The block SHALL have port al_veri, input, width 8, received byte from the UART receiver.
REQ-006 The block SHALL have port al_gecerli, input, width 1, one-cycle strobe marking al_veri valid.
REQ-007 The block SHALL have port veri_hazir, input, width 1, consumer ready.
REQ-008 The block SHALL have port temizle, input, width 1, synchronous flush and clear of the overflow flag.
REQ-009 The block SHALL have port veri, output, width 32, the head byte zero-extended as {24'b0, byte}.
REQ-010 The block SHALL have port veri_gecerli, output, width 1, asserted when the FIFO is non-empty.
REQ-011 The block SHALL have port doluluk, output, width clog2(DERINLIK)+1, current entry count.
REQ-012 The block SHALL have port yari_dolu, output, width 1, asserted when doluluk >= ESIK.
REQ-013 The block SHALL have port tasma, output, width 1, sticky overflow flag.

Function
REQ-014 A push SHALL occur on a rising edge where al_gecerli=1, temizle=0, rst_g=0, and either doluluk<DERINLIK or a pop occurs on the same edge.
REQ-015 A pop SHALL occur on a rising edge where veri_gecerli=1, veri_hazir=1, temizle=0 and rst_g=0.
REQ-016 Data SHALL fall through: a byte pushed into an empty FIFO at edge N SHALL appear on veri with veri_gecerli=1 from edge N onward, giving one cycle of latency.
REQ-017 veri SHALL be 32'h0 whenever veri_gecerli=0, and veri[31:8] SHALL always be 0.
REQ-018 veri, veri_gecerli, doluluk and yari_dolu SHALL be registered or derived from registered state only, with no combinational path from al_gecerli, al_veri or veri_hazir.
REQ-019 When both a push and a pop occur on the same edge, doluluk SHALL be unchanged and byte order SHALL be preserved; this applies at full and at doluluk=1.
REQ-020 When al_gecerli=1 arrives with doluluk=DERINLIK and no pop, the byte SHALL be dropped, FIFO contents SHALL be unchanged, and tasma SHALL be set to 1 from the next edge.
REQ-021 tasma SHALL remain 1 until temizle or rst_g, and further overflows SHALL have no additional effect.
REQ-022 When temizle=1 at an edge, doluluk SHALL become 0, the pointers SHALL become 0 and tasma SHALL become 0; any same-edge push, pop or overflow SHALL be ignored.
REQ-023 Read and write pointers SHALL wrap modulo DERINLIK, with no bubble or loss at wrap-around.
REQ-024 doluluk SHALL never exceed DERINLIK nor underflow below 0.
REQ-025 Output order SHALL be strictly FIFO: bytes SHALL leave in the order they were accepted.
REQ-026 A pop with veri_gecerli=0 SHALL have no effect, so veri_hazir is don't-care when the FIFO is empty.

Reset
REQ-027 When rst_g=1 at an edge, the block SHALL set doluluk=0, pointers=0, tasma=0, veri_gecerli=0, veri=32'h0 and yari_dolu=0.
REQ-028 Reset SHALL take priority over temizle, push and pop.
REQ-029 Reset asserted mid-stream SHALL discard all stored bytes.
REQ-030 Storage array contents SHALL need no reset.
REQ-031 rst_g SHALL be asserted for at least 1 cycle, and behaviour SHALL be defined from the first edge after rst_g falls.

Verification
REQ-032 With veri_hazir=0, push 0x41 at edge N; veri SHALL be 32'h00000041, veri_gecerli=1 and doluluk=1 after edge N, then veri_hazir=1 for one cycle SHALL return veri_gecerli=0 and veri=0.
REQ-033 With DERINLIK=8, ESIK=6, push 0x00..0x07; yari_dolu SHALL rise after the 6th push, and a 9th push of 0x08 SHALL set tasma=1 while doluluk stays 8; draining SHALL yield 0x00..0x07 with 0x08 absent.
REQ-034 When full, al_gecerli and veri_hazir SHALL be asserted together with 0x55; the pop SHALL yield the head byte, 0x55 SHALL be accepted, doluluk stays 8 and tasma stays 0.
REQ-035 A continuous stream of 20 bytes with veri_hazir=1 throughout SHALL be received in order across pointer wrap, with doluluk never exceeding 1 and tasma=0.
REQ-036 With 3 bytes stored and tasma=1, temizle asserted together with al_gecerli (0x99) SHALL give doluluk=0, veri_gecerli=0 and tasma=0 on the next cycle, and 0x99 SHALL not be stored.
REQ-037 With 5 bytes stored, rst_g asserted for one cycle SHALL zero all outputs, and a subsequent push of 0x12 SHALL appear as the sole entry.
